// File: rtl/lamp_pkg.sv
// rtl/lamp_pkg.sv - shared state encoding and defaults for the lamp switch conditioner
package lamp_pkg;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_SETTLING = 1'b1
  } db_state_t;

  localparam int DB_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/db_channel.sv
// rtl/db_channel.sv - one switch channel: 2-flop synchronizer, settle FSM and debounce counter
module db_channel
  import lamp_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic s
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  db_state_t     state;
  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      state <= ST_STABLE;
      cnt   <= '0;
      s     <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      case (state)
        ST_STABLE: begin
          if (sync2 != s) begin
            state <= ST_SETTLING;
            cnt   <= CW'(1);
          end
        end
        ST_SETTLING: begin
          // Any sample matching the current output aborts the settle run
          if (sync2 == s) begin
            state <= ST_STABLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            s     <= sync2;
            state <= ST_STABLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= ST_STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/lamp_switch_cond.sv
// rtl/lamp_switch_cond.sv - three debounced wall switches plus change pulse (TGL enabled by LAMP_SWITCH_TGL_EN)
module lamp_switch_cond
  import lamp_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic SW1_RAW,
  input  logic SW2_RAW,
  input  logic SW3_RAW,
  output logic S1,
  output logic S2,
  output logic S3,
  output logic TGL
);

  db_channel #(.DB_CYCLES(DB_CYCLES)) u_ch1 (.clk(clk), .rst(rst), .raw(SW1_RAW), .s(S1));
  db_channel #(.DB_CYCLES(DB_CYCLES)) u_ch2 (.clk(clk), .rst(rst), .raw(SW2_RAW), .s(S2));
  db_channel #(.DB_CYCLES(DB_CYCLES)) u_ch3 (.clk(clk), .rst(rst), .raw(SW3_RAW), .s(S3));

`ifdef LAMP_SWITCH_TGL_EN
  logic [2:0] s_prev;

  // One pulse per edge on which any channel moved, however many moved together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_prev <= 3'b000;
      TGL    <= 1'b0;
    end else begin
      s_prev <= {S1, S2, S3};
      TGL    <= ({S1, S2, S3} != s_prev);
    end
  end
`else
  assign TGL = 1'b0;
`endif

endmodule

// File: tb/tb_lamp_switch_cond.sv
// tb/tb_lamp_switch_cond.sv - scoreboard bench with directed and random switch activity
module tb_lamp_switch_cond;

  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sw1 = 1'b1;
  logic sw2 = 1'b1;
  logic sw3 = 1'b1;
  logic s1, s2, s3, tgl;

  int vectors = 0;
  int miscompares = 0;

  logic [3:0] exp_q[$];

  bit dl[3][$];
  bit hist[3][$];
  bit s_m[3];
  bit chg_last;

  always #5 clk = ~clk;

  lamp_switch_cond #(.DB_CYCLES(DB)) dut (
    .clk(clk), .rst(rst),
    .SW1_RAW(sw1), .SW2_RAW(sw2), .SW3_RAW(sw3),
    .S1(s1), .S2(s2), .S3(s3), .TGL(tgl)
  );

  // Reference: an output flips once the last DB synchronized samples since
  // its previous flip all disagree with it; samples lag the raw pin by two edges.
  always @(posedge clk) begin
    bit raw_now[3];
    bit seen;
    bit all_diff;
    bit chg;
    bit tgl_exp;
    raw_now[0] = sw1;
    raw_now[1] = sw2;
    raw_now[2] = sw3;
    if (rst) begin
      for (int c = 0; c < 3; c++) begin
        dl[c].delete();
        dl[c].push_back(1'b0);
        dl[c].push_back(1'b0);
        hist[c].delete();
        s_m[c] = 1'b0;
      end
      chg_last = 1'b0;
      exp_q.push_back(4'b0000);
    end else begin
      chg = 1'b0;
      for (int c = 0; c < 3; c++) begin
        seen = dl[c].pop_front();
        dl[c].push_back(raw_now[c]);
        hist[c].push_back(seen);
        if (hist[c].size() > DB) void'(hist[c].pop_front());
        if (hist[c].size() == DB) begin
          all_diff = 1'b1;
          for (int k = 0; k < DB; k++)
            if (hist[c][k] == s_m[c]) all_diff = 1'b0;
          if (all_diff) begin
            s_m[c] = ~s_m[c];
            hist[c].delete();
            chg = 1'b1;
          end
        end
      end
`ifdef LAMP_SWITCH_TGL_EN
      tgl_exp = chg_last;
`else
      tgl_exp = 1'b0;
`endif
      chg_last = chg;
      exp_q.push_back({s_m[0], s_m[1], s_m[2], tgl_exp});
    end
  end

  initial begin
    logic [3:0] e;
    forever begin
      @(posedge clk);
      #2;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_empty t=%0t", $time);
      end else begin
        e = exp_q.pop_front();
        if ({s1, s2, s3, tgl} !== e) begin
          miscompares++;
          $display("FAIL outputs t=%0t got S1S2S3TGL=%b want=%b", $time, {s1, s2, s3, tgl}, e);
        end
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_raw(input logic [2:0] v);
    {sw1, sw2, sw3} = v;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    #1;
    vectors++;
    if ({s1, s2, s3, tgl} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_immediate t=%0t got=%b want=0000", $time, {s1, s2, s3, tgl});
    end
    hold(n);
    rst = 1'b0;
  endtask

  initial begin
    hold(3);
    rst = 1'b0;
    hold(10);

    @(negedge clk);
    set_raw(3'b000);
    do_reset(2);
    hold(10);

    set_raw(3'b100);
    hold(12);

    set_raw(3'b110); hold(1);
    set_raw(3'b100); hold(1);
    set_raw(3'b110); hold(1);
    set_raw(3'b100); hold(1);
    set_raw(3'b110); hold(12);

    set_raw(3'b111); hold(3);
    set_raw(3'b110); hold(12);

    set_raw(3'b000); hold(12);
    set_raw(3'b111); hold(12);

    set_raw(3'b000); hold(12);
    set_raw(3'b111); hold(4);
    do_reset(2);
    hold(12);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) sw1 = ~sw1;
      if ($urandom_range(0, 5) == 0) sw2 = ~sw2;
      if ($urandom_range(0, 5) == 0) sw3 = ~sw3;
      if ($urandom_range(0, 299) == 0) do_reset($urandom_range(1, 3));
      else hold(1);
    end

    hold(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lamp_switch_cond.md
LAMP_SWITCH_COND -- requirements
Module: lamp_switch_cond

Interface
REQ-001 Parameter: DB_CYCLES, default 4, number of consecutive stable synchronized samples required before a debounced output changes (legal range 2..65535).
REQ-002 Port: clk  input  1  single rising-edge clock for all state.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: SW1_RAW  input  1  raw, asynchronous, bouncing wall switch 1.
REQ-005 Port: SW2_RAW  input  1  raw, asynchronous, bouncing wall switch 2.
REQ-006 Port: SW3_RAW  input  1  raw, asynchronous, bouncing wall switch 3.
REQ-007 Port: S1  output  1  debounced switch 1, feeds the lamp-control stage S1 input.
REQ-008 Port: S2  output  1  debounced switch 2, feeds the lamp-control stage S2 input.
REQ-009 Port: S3  output  1  debounced switch 3, feeds the lamp-control stage S3 input.
REQ-010 Port: TGL  output  1  one-cycle pulse when any of S1..S3 changes (see Configuration).

Function
REQ-011 Each channel SHALL pass its raw input through a 2-flop synchronizer (sync1, sync2), reset to 0.
REQ-012 Each channel SHALL run a 2-state FSM: STABLE (sync2 == Sn) and SETTLING (sync2 != Sn).
REQ-013 STABLE: counter held at 0; on an edge sampling sync2 != Sn, go to SETTLING with counter = 1.
REQ-014 SETTLING: on an edge sampling sync2 == Sn, return to STABLE and clear counter; Sn unchanged.
REQ-015 SETTLING: on an edge sampling sync2 != Sn with counter == DB_CYCLES-1, Sn <= sync2, counter cleared, go to STABLE.
REQ-016 SETTLING: otherwise counter increments by 1; counter width = ceil(log2(DB_CYCLES)) bits, never wraps.
REQ-017 Latency: a raw change held stable SHALL appear on Sn at rising edge DB_CYCLES+2, counting the first edge that samples the new raw value as edge 1.
REQ-018 A synchronized disturbance lasting fewer than DB_CYCLES sampled cycles SHALL NOT change Sn.
REQ-019 Channels SHALL be fully independent; simultaneous changes on several channels SHALL each update on their own schedule, possibly on the same edge.
REQ-020 Sn SHALL be registered outputs (glitch-free, no combinational path from raw inputs).

Reset
REQ-021 Asserting rst at any time, including mid-SETTLING, SHALL immediately force sync flops, counters, S1..S3 and TGL to 0 and all FSMs to STABLE.
REQ-022 After rst deasserts with raw input at 1, Sn SHALL rise through the normal DB_CYCLES+2 debounce path (no bypass).

Configuration
REQ-023 Macro LAMP_SWITCH_TGL_EN: when defined, TGL SHALL be a registered pulse, high for exactly one cycle, on the edge after any Sn changes (multiple channels changing on one edge give a single pulse).
REQ-024 Without LAMP_SWITCH_TGL_EN, TGL SHALL be constant 0 and the pulse logic SHALL be absent; S1..S3 behaviour is identical in both builds.

Structure
REQ-025 Shared package lamp_pkg SHALL hold the FSM state encoding (ST_STABLE, ST_SETTLING) and default DB_CYCLES constant.
REQ-026 One sub-module db_channel (synchronizer + FSM + counter, parameter DB_CYCLES) SHALL be instantiated three times; the top holds only instances and the TGL logic.

Verification (DB_CYCLES = 4, TGL_EN defined unless stated)
REQ-027 Reset: rst=1 with SW*_RAW=1 -> S1..S3=0, TGL=0 throughout reset; after release S1..S3=1 at edge 6, TGL pulse at edge 7.
REQ-028 Clean step: SW1_RAW 0->1 held -> S1 rises at edge 6 exactly, S2/S3 remain 0, one TGL pulse.
REQ-029 Bounce: SW2_RAW toggles 1,0,1,0 every cycle then holds 1 -> S2 stays 0 during bounce, rises 6 edges after final transition.
REQ-030 Short glitch: SW3_RAW high for 3 cycles then back to 0 -> S3 never changes, TGL never pulses.
REQ-031 Simultaneous: all three raw inputs 0->1 same cycle -> S1..S3 rise on the same edge, single TGL pulse; rst asserted mid-SETTLING -> outputs 0 immediately.
REQ-032 Build without LAMP_SWITCH_TGL_EN: rerun REQ-028 -> identical S1 timing, TGL constant 0.
